// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: valid/ready burst master in front of a single-port sync memory.
// Define MEM_BURST_WRAP_EN to allow bursts that wrap modulo DEPTH.
module mem_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  m_valid_o,
  output logic                  m_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WIDTH-1:0]      m_wdata_o,
  input  logic [WIDTH-1:0]      m_rdata_i,
  input  logic                  m_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ACC,
    S_W_ISS,
    S_R_ISS,
    S_R_CAPT,
    S_R_OUT,
    S_DONE
  } state_t;

  localparam logic [LEN_WIDTH:0] DEPTH_L = (LEN_WIDTH+1)'(DEPTH);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]      wdata_q, rdata_q;
  logic                  cmd_ready_q, wr_ready_q, rd_valid_q;
  logic                  done_q, err_q, m_valid_q, m_wr_rd_q;
  logic [LEN_WIDTH:0]    len_x;
  logic                  len_ok, cmd_legal, last_beat;

  assign len_x  = {1'b0, cmd_len_i};
  assign len_ok = (cmd_len_i != '0) && (len_x <= DEPTH_L);

`ifdef MEM_BURST_WRAP_EN
  assign cmd_legal = len_ok;
`else
  logic [LEN_WIDTH:0] end_x;
  assign end_x     = len_x + (LEN_WIDTH+1)'(cmd_addr_i);
  assign cmd_legal = len_ok && (end_x <= DEPTH_L);
`endif

  assign addr_d    = addr_q + ADDR_WIDTH'(1);
  assign cnt_d     = cnt_q - LEN_WIDTH'(1);
  assign last_beat = (cnt_q == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_wr_rd_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_wr_rd_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            if (cmd_legal) begin
              addr_q      <= cmd_addr_i;
              cnt_q       <= cmd_len_i;
              cmd_ready_q <= 1'b0;
              if (cmd_wr_i) begin
                state_q    <= S_W_ACC;
                wr_ready_q <= 1'b1;
              end else begin
                state_q   <= S_R_ISS;
                m_valid_q <= 1'b1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_W_ACC: begin
          if (wr_valid_i) begin
            wdata_q    <= wr_data_i;
            wr_ready_q <= 1'b0;
            m_valid_q  <= 1'b1;
            m_wr_rd_q  <= 1'b1;
            state_q    <= S_W_ISS;
          end
        end
        S_W_ISS: begin
          cnt_q  <= cnt_d;
          addr_q <= addr_d;
          if (last_beat) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_W_ACC;
            wr_ready_q <= 1'b1;
          end
        end
        S_R_ISS: begin
          state_q <= S_R_CAPT;
        end
        S_R_CAPT: begin
          // A not-ready memory is flagged but the captured word still goes out
          rdata_q    <= m_rdata_i;
          err_q      <= ~m_ready_i;
          rd_valid_q <= 1'b1;
          state_q    <= S_R_OUT;
        end
        S_R_OUT: begin
          if (rd_ready_i) begin
            rd_valid_q <= 1'b0;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            if (last_beat) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_R_ISS;
              m_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign m_valid_o   = m_valid_q;
  assign m_wr_rd_o   = m_wr_rd_q;
  assign m_addr_o    = addr_q;
  assign m_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed + random bursts against a memory array model.
// Honours MEM_BURST_WRAP_EN for the legality of wrapping commands.
`timescale 1ns/1ps
module tb_mem_burst_ctrl;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_valid = 1'b0, rd_ready = 1'b0, m_ready = 1'b1;
  logic          cmd_ready, wr_ready, rd_valid, done, err;
  logic          m_valid, m_wr_rd;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata, rd_data;
  logic [W-1:0]  m_rdata = '0;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .done_o(done), .err_o(err),
    .m_valid_o(m_valid), .m_wr_rd_o(m_wr_rd), .m_addr_o(m_addr),
    .m_wdata_o(m_wdata), .m_rdata_i(m_rdata), .m_ready_i(m_ready)
  );

  // Synchronous single-port memory with one-cycle read latency
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (m_valid) begin
      if (m_wr_rd) mem[m_addr] <= m_wdata;
      else m_rdata <= mem[m_addr];
    end
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } acc_t;

  acc_t acc_q[$];
  int   done_n = 0;
  int   err_n = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid) acc_q.push_back('{m_wr_rd, m_addr, m_wdata});
    if (done) done_n++;
    if (err) err_n++;
  end

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] wbuf [D];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int a, input int l);
`ifdef MEM_BURST_WRAP_EN
    return (l >= 1) && (l <= D);
`else
    return (l >= 1) && (l <= D) && (a + l <= D);
`endif
  endfunction

  task automatic issue_cmd(input logic wr, input int a, input int l);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_rdy_to", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(l);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr_burst(input int a, input int l);
    int n0, d0, e0, w;
    acc_t e;
    n0 = acc_q.size();
    d0 = done_n;
    e0 = err_n;
    issue_cmd(1'b1, a, l);
    for (int b = 0; b < l; b++) begin
      wr_data  = wbuf[b];
      wr_valid = 1'b1;
      w = 0;
      while (wr_ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("wr_rdy_to", 32'(wr_ready), 1);
      @(negedge clk);
      chk("w_issue", 32'({m_valid, m_wr_rd}), 3);
      chk("w_addr", 32'(m_addr), (a + b) % D);
    end
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("w_done", done_n - d0, 1);
    chk("w_noerr", err_n - e0, 0);
    chk("w_nacc", acc_q.size() - n0, l);
    for (int b = 0; b < l && n0 + b < acc_q.size(); b++) begin
      e = acc_q[n0 + b];
      chk("w_acc", 32'({e.wr, e.a, e.d}),
          32'({1'b1, AW'((a + b) % D), wbuf[b]}));
    end
    for (int b = 0; b < l; b++) ref_mem[(a + b) % D] = wbuf[b];
  endtask

  task automatic rd_burst(input int a, input int l, input int stall,
                          input bit merr);
    int n0, n1, d0, e0, t0, tp, w;
    logic [W-1:0] hold;
    acc_t e;
    n0 = acc_q.size();
    d0 = done_n;
    e0 = err_n;
    m_ready  = ~merr;
    rd_ready = (stall == 0);
    issue_cmd(1'b0, a, l);
    t0 = cyc;
    tp = cyc;
    for (int b = 0; b < l; b++) begin
      w = 0;
      while (rd_valid !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("rd_vld_to", 32'(rd_valid), 1);
      // accept edge -> R_ISSUE -> R_CAPT -> R_OUT: visible two edges later
      if (b == 0) chk("rd_lat", cyc - t0, 2);
      else chk("rd_rate", cyc - tp, 3);
      chk("rd_data", 32'(rd_data), 32'(ref_mem[(a + b) % D]));
      if (b == 0 && stall > 0) begin
        hold = rd_data;
        n1   = acc_q.size();
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("rd_hold_v", 32'(rd_valid), 1);
          chk("rd_hold_d", 32'(rd_data), 32'(hold));
        end
        chk("rd_hold_nomem", acc_q.size() - n1, 0);
        rd_ready = 1'b1;
      end
      tp = cyc;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    m_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("r_done", done_n - d0, 1);
    chk("r_err", err_n - e0, merr ? l : 0);
    chk("r_nacc", acc_q.size() - n0, l);
    for (int b = 0; b < l && n0 + b < acc_q.size(); b++) begin
      e = acc_q[n0 + b];
      chk("r_acc", 32'({e.wr, e.a}), 32'({1'b0, AW'((a + b) % D)}));
    end
  endtask

  task automatic bad_cmd(input logic wr, input int a, input int l);
    int n0, d0, e0;
    n0 = acc_q.size();
    d0 = done_n;
    e0 = err_n;
    issue_cmd(wr, a, l);
    chk("bad_err", 32'(err), 1);
    chk("bad_rdy", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    chk("bad_errn", err_n - e0, 1);
    chk("bad_noacc", acc_q.size() - n0, 0);
    chk("bad_nodone", done_n - d0, 0);
  endtask

  initial begin
    int a, l, n0, d0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({cmd_ready, wr_ready, rd_valid, done, err,
                        m_valid, m_wr_rd}), 0);
    chk("rst_dat", 32'({m_addr, m_wdata, rd_data}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(cmd_ready), 1);

    for (int i = 0; i < D; i++) wbuf[i] = W'($urandom);
    wr_burst(0, D);

    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    wbuf[2] = 16'h3333;
    wr_burst(2, 3);
    rd_burst(2, 3, 0, 1'b0);
    chk("rd_const", 32'(ref_mem[3]), 32'h2222);
    rd_burst(0, 2, 5, 1'b0);

`ifdef MEM_BURST_WRAP_EN
    rd_burst(14, 4, 0, 1'b0);
`else
    bad_cmd(1'b0, 14, 4);
`endif

    for (int i = 0; i < 4; i++) wbuf[i] = W'($urandom);
    wr_burst(12, 4);
    rd_burst(12, 4, 0, 1'b0);
    bad_cmd(1'b0, 0, 0);
    bad_cmd(1'b1, 0, D + 1);
    rd_burst(7, 1, 0, 1'b1);

    n0 = acc_q.size();
    d0 = done_n;
    issue_cmd(1'b1, 5, 4);
    wr_data  = 16'hA5A5;
    wr_valid = 1'b1;
    a = 0;
    while (wr_ready !== 1'b1 && a < 20) begin
      @(negedge clk);
      a++;
    end
    @(negedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", 32'({cmd_ready, wr_ready, rd_valid, done, err,
                            m_valid, m_wr_rd}), 0);
    chk("mid_rst_dat", 32'({m_addr, m_wdata, rd_data}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_done", done_n - d0, 0);
    chk("mid_rst_acc", acc_q.size() - n0, 1);
    ref_mem[5] = 16'hA5A5;
    rd_burst(4, 3, 0, 1'b0);

    for (int it = 0; it < 14; it++) begin
      a = $urandom_range(0, D - 1);
      if ($urandom_range(0, 5) == 0) l = $urandom_range(0, D + 1);
      else l = $urandom_range(1, 6);
      if (!legal(a, l)) begin
        bad_cmd(1'($urandom_range(0, 1)), a, l);
      end else if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < l; i++) wbuf[i] = W'($urandom);
        wr_burst(a, l);
      end else begin
        rd_burst(a, l, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
